// File: rtl/kbd_pkg.sv
// ============================================================================
// Module      : kbd_pkg
// Description : Shared constants, LED FSM state type and a drop-counter helper
//               for the keyboard event scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package kbd_pkg;

    localparam int KEY_CLK_TICKS = 1431;
    localparam int FRAME_TICKS   = 40;
    localparam int EVT_W         = 16;
    localparam int LED_W         = 2;
    localparam int FIFO_W        = EVT_W + 1;   // {is_mouse, payload}

    typedef enum logic [1:0] {
        LED_IDLE  = 2'd0,
        LED_ISSUE = 2'd1,
        LED_HOLD  = 2'd2
    } led_state_t;

    // Saturating drop counter; a clear wins over history but still counts
    // a drop that lands in the same cycle.
    function automatic logic [7:0] drop_cnt_next(input logic [7:0] cnt,
                                                 input logic       drop,
                                                 input logic       clr);
        logic [7:0] nxt;
        nxt = cnt;
        if (clr) begin
            nxt = drop ? 8'd1 : 8'd0;
        end else if (drop && (cnt != 8'hFF)) begin
            nxt = cnt + 8'd1;
        end
        return nxt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/kbd_event_sched_if.sv
// ============================================================================
// Module      : kbd_event_sched_if
// Description : Valid/ready event stream from the scheduler to the consumer.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface kbd_event_sched_if;
    import kbd_pkg::*;

    logic             evt_valid;
    logic             evt_ready;
    logic             evt_is_mouse;
    logic [EVT_W-1:0] evt_data;

    modport master (
        output evt_valid,
        output evt_is_mouse,
        output evt_data,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_is_mouse,
        input  evt_data,
        output evt_ready
    );

endinterface

`default_nettype wire

// File: rtl/sched_fifo.sv
// ============================================================================
// Module      : sched_fifo
// Description : Synchronous FIFO with extra-MSB pointers. A push into a full
//               FIFO is accepted only when a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sched_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update; both wrap naturally through the extra MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage write; contents need no reset since empty masks them.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

`default_nettype wire

// File: rtl/kbd_event_sched.sv
// ============================================================================
// Module      : kbd_event_sched
// Description : Captures keyboard/mouse packets into two FIFOs, merges them
//               round-robin onto one valid/ready stream, and issues
//               rate-limited LED commands from two requesters.
//               Optional macro KBD_SCHED_DROP_CNT_EN adds saturating
//               per-source drop counters (kb_drop_cnt, ms_drop_cnt).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module kbd_event_sched
    import kbd_pkg::*;
#(
    parameter int KB_DEPTH    = 8,
    parameter int MS_DEPTH    = 4,
    parameter int LED_HOLDOFF = FRAME_TICKS * KEY_CLK_TICKS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              kb_data_avail,
    input  logic              kb_is_mouse,
    input  logic [EVT_W-1:0]  kb_data,
    kbd_event_sched_if.master evt,
    output logic              kb_ovf,
    output logic              ms_ovf,
    input  logic              ovf_clr,
    input  logic              led_req_host,
    input  logic [LED_W-1:0]  led_host,
    input  logic              led_req_local,
    input  logic [LED_W-1:0]  led_local,
    output logic              led_data_valid,
    output logic [LED_W-1:0]  led_data_out
`ifdef KBD_SCHED_DROP_CNT_EN
    ,
    output logic [7:0]        kb_drop_cnt,
    output logic [7:0]        ms_drop_cnt
`endif
);

    localparam logic [15:0] HOLD_LOAD = 16'(LED_HOLDOFF - 1);
    // IDLE and ISSUE each take one cycle of the holdoff, so HOLD hands
    // over two counts early to keep commands exactly LED_HOLDOFF apart.
    localparam logic [15:0] HOLD_EXIT = 16'd2;

    // ------------------------------------------------------------------
    // Capture and FIFOs
    // ------------------------------------------------------------------
    logic              avail_q;
    logic              push_pulse;
    logic              kb_push, ms_push, kb_pop, ms_pop;
    logic              kb_full, ms_full, kb_empty, ms_empty;
    logic              kb_drop, ms_drop;
    logic [FIFO_W-1:0] kb_dout, ms_dout, sel_dout;

    assign push_pulse = kb_data_avail & ~avail_q;
    assign kb_push    = push_pulse & ~kb_is_mouse;
    assign ms_push    = push_pulse &  kb_is_mouse;
    assign kb_drop    = kb_push & kb_full & ~kb_pop;
    assign ms_drop    = ms_push & ms_full & ~ms_pop;

    // Edge detector on the data-available level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) avail_q <= 1'b0;
        else        avail_q <= kb_data_avail;
    end

    sched_fifo #(.DEPTH(KB_DEPTH), .WIDTH(FIFO_W)) u_kb_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (kb_push),
        .pop   (kb_pop),
        .din   ({1'b0, kb_data}),
        .dout  (kb_dout),
        .full  (kb_full),
        .empty (kb_empty)
    );

    sched_fifo #(.DEPTH(MS_DEPTH), .WIDTH(FIFO_W)) u_ms_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (ms_push),
        .pop   (ms_pop),
        .din   ({1'b1, kb_data}),
        .dout  (ms_dout),
        .full  (ms_full),
        .empty (ms_empty)
    );

    // ------------------------------------------------------------------
    // Round-robin merge into a single output register slice
    // ------------------------------------------------------------------
    logic             evt_valid_q;
    logic             evt_is_mouse_q;
    logic [EVT_W-1:0] evt_data_q;
    logic             last_grant_q;     // 1 = mouse was granted last
    logic             load_en, grant_kb, grant_ms;

    assign load_en  = ~evt_valid_q | evt.evt_ready;
    assign grant_ms = ~ms_empty & (kb_empty | ~last_grant_q);
    assign grant_kb = ~kb_empty & ~grant_ms;
    assign kb_pop   = load_en & grant_kb;
    assign ms_pop   = load_en & grant_ms;
    assign sel_dout = grant_ms ? ms_dout : kb_dout;

    assign evt.evt_valid    = evt_valid_q;
    assign evt.evt_is_mouse = evt_is_mouse_q;
    assign evt.evt_data     = evt_data_q;

    // Output slice; last_grant resets to mouse so keyboard wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_valid_q    <= 1'b0;
            evt_is_mouse_q <= 1'b0;
            evt_data_q     <= '0;
            last_grant_q   <= 1'b1;
        end else if (load_en) begin
            if (grant_kb | grant_ms) begin
                evt_valid_q                  <= 1'b1;
                {evt_is_mouse_q, evt_data_q} <= sel_dout;
                last_grant_q                 <= grant_ms;
            end else begin
                evt_valid_q <= 1'b0;
            end
        end
    end

    // Sticky overflow flags; a new drop beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kb_ovf <= 1'b0;
            ms_ovf <= 1'b0;
        end else begin
            if (kb_drop)      kb_ovf <= 1'b1;
            else if (ovf_clr) kb_ovf <= 1'b0;
            if (ms_drop)      ms_ovf <= 1'b1;
            else if (ovf_clr) ms_ovf <= 1'b0;
        end
    end

`ifdef KBD_SCHED_DROP_CNT_EN
    logic [7:0] kb_drop_cnt_q, ms_drop_cnt_q;

    // Saturating per-source drop counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kb_drop_cnt_q <= 8'd0;
            ms_drop_cnt_q <= 8'd0;
        end else begin
            kb_drop_cnt_q <= drop_cnt_next(kb_drop_cnt_q, kb_drop, ovf_clr);
            ms_drop_cnt_q <= drop_cnt_next(ms_drop_cnt_q, ms_drop, ovf_clr);
        end
    end

    assign kb_drop_cnt = kb_drop_cnt_q;
    assign ms_drop_cnt = ms_drop_cnt_q;
`endif

    // ------------------------------------------------------------------
    // LED request arbitration and holdoff
    // ------------------------------------------------------------------
    logic             pend_host_q, pend_local_q;
    logic [LED_W-1:0] val_host_q, val_local_q;
    led_state_t       state_q, state_d;
    logic             grant_local_q, grant_local_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [LED_W-1:0] led_out_q, led_out_d;
    logic             clr_host, clr_local;

    assign led_data_out = led_out_q;

    // Pending latches; a request in the issue cycle survives the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_host_q  <= 1'b0;
            pend_local_q <= 1'b0;
            val_host_q   <= '0;
            val_local_q  <= '0;
        end else begin
            if (led_req_host) begin
                pend_host_q <= 1'b1;
                val_host_q  <= led_host;
            end else if (clr_host) begin
                pend_host_q <= 1'b0;
            end
            if (led_req_local) begin
                pend_local_q <= 1'b1;
                val_local_q  <= led_local;
            end else if (clr_local) begin
                pend_local_q <= 1'b0;
            end
        end
    end

    // LED FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= LED_IDLE;
            grant_local_q <= 1'b0;
            cnt_q         <= '0;
            led_out_q     <= '0;
        end else begin
            state_q       <= state_d;
            grant_local_q <= grant_local_d;
            cnt_q         <= cnt_d;
            led_out_q     <= led_out_d;
        end
    end

    // LED FSM next state: host has fixed priority over local.
    always_comb begin
        state_d        = state_q;
        grant_local_d  = grant_local_q;
        cnt_d          = cnt_q;
        led_out_d      = led_out_q;
        led_data_valid = 1'b0;
        clr_host       = 1'b0;
        clr_local      = 1'b0;
        case (state_q)
            LED_IDLE: begin
                if (pend_host_q) begin
                    grant_local_d = 1'b0;
                    led_out_d     = val_host_q;
                    state_d       = LED_ISSUE;
                end else if (pend_local_q) begin
                    grant_local_d = 1'b1;
                    led_out_d     = val_local_q;
                    state_d       = LED_ISSUE;
                end
            end
            LED_ISSUE: begin
                led_data_valid = 1'b1;
                clr_host       = ~grant_local_q;
                clr_local      =  grant_local_q;
                cnt_d          = HOLD_LOAD;
                state_d        = LED_HOLD;
            end
            LED_HOLD: begin
                cnt_d = cnt_q - 16'd1;
                if (cnt_q <= HOLD_EXIT) state_d = LED_IDLE;
            end
            default: state_d = LED_IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_kbd_event_sched.sv
// ============================================================================
// Module      : tb_kbd_event_sched
// Description : Self-checking bench for kbd_event_sched (directed scenarios
//               plus randomized traffic against a queue-based model).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_kbd_event_sched;
    import kbd_pkg::*;

    localparam int KB_D = 8;
    localparam int MS_D = 4;
    localparam int HOLD = 50;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             kb_data_avail, kb_is_mouse, ovf_clr;
    logic [15:0]      kb_data;
    logic             kb_ovf, ms_ovf;
    logic             led_req_host, led_req_local, led_data_valid;
    logic [1:0]       led_host, led_local, led_data_out;
`ifdef KBD_SCHED_DROP_CNT_EN
    logic [7:0]       kb_drop_cnt, ms_drop_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int pulse_n;
    int pulse_t [8];
    logic [1:0] pulse_v [8];

    kbd_event_sched_if evt_if ();

    kbd_event_sched #(.KB_DEPTH(KB_D), .MS_DEPTH(MS_D), .LED_HOLDOFF(HOLD)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .kb_data_avail  (kb_data_avail),
        .kb_is_mouse    (kb_is_mouse),
        .kb_data        (kb_data),
        .evt            (evt_if),
        .kb_ovf         (kb_ovf),
        .ms_ovf         (ms_ovf),
        .ovf_clr        (ovf_clr),
        .led_req_host   (led_req_host),
        .led_host       (led_host),
        .led_req_local  (led_req_local),
        .led_local      (led_local),
        .led_data_valid (led_data_valid),
        .led_data_out   (led_data_out)
`ifdef KBD_SCHED_DROP_CNT_EN
        ,
        .kb_drop_cnt    (kb_drop_cnt),
        .ms_drop_cnt    (ms_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n = 1'b0; kb_data_avail = 1'b0; kb_is_mouse = 1'b0; kb_data = '0;
        evt_if.evt_ready = 1'b0; ovf_clr = 1'b0;
        led_req_host = 1'b0; led_host = '0; led_req_local = 1'b0; led_local = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One capture: avail high for one cycle, then low for one cycle.
    task automatic push_evt(input logic m, input logic [15:0] d);
        kb_data_avail = 1'b1; kb_is_mouse = m; kb_data = d;
        @(negedge clk);
        kb_data_avail = 1'b0;
        @(negedge clk);
    endtask

    // Drives an LED request schedule (t = -1 means unused) and records pulses.
    task automatic led_window(input int len,
                              input int h0, input logic [1:0] v0,
                              input int h1, input logic [1:0] v1,
                              input int h2, input logic [1:0] v2,
                              input int l0, input logic [1:0] lv);
        pulse_n = 0;
        for (int i = 0; i < 8; i++) begin pulse_t[i] = -1; pulse_v[i] = 2'b00; end
        for (int t = 0; t < len; t++) begin
            if (led_data_valid === 1'b1 && pulse_n < 8) begin
                pulse_t[pulse_n] = t; pulse_v[pulse_n] = led_data_out; pulse_n++;
            end
            led_req_host  = (t == h0) || (t == h1) || (t == h2);
            led_host      = (t == h0) ? v0 : ((t == h1) ? v1 : v2);
            led_req_local = (t == l0);
            led_local     = lv;
            @(negedge clk);
            led_req_host  = 1'b0;
            led_req_local = 1'b0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (evt_if.evt_valid !== 1'b0) begin errors++; $display("FAIL reset_evt_valid got %0b want 0", evt_if.evt_valid); end
        checks++; if (evt_if.evt_data !== 16'h0) begin errors++; $display("FAIL reset_evt_data got %0h want 0", evt_if.evt_data); end
        checks++; if ({kb_ovf, ms_ovf} !== 2'b00) begin errors++; $display("FAIL reset_ovf got %0b want 00", {kb_ovf, ms_ovf}); end
        checks++; if (led_data_valid !== 1'b0) begin errors++; $display("FAIL reset_led_valid got %0b want 0", led_data_valid); end
        checks++; if (led_data_out !== 2'b00) begin errors++; $display("FAIL reset_led_out got %0b want 00", led_data_out); end
`ifdef KBD_SCHED_DROP_CNT_EN
        checks++; if ({kb_drop_cnt, ms_drop_cnt} !== 16'h0) begin errors++; $display("FAIL reset_drop_cnt got %0h want 0", {kb_drop_cnt, ms_drop_cnt}); end
`endif
    endtask

    task automatic test_single_push();
        int n;
        evt_if.evt_ready = 1'b0;
        kb_data_avail = 1'b1; kb_is_mouse = 1'b0; kb_data = 16'h3A15;
        @(negedge clk);
        checks++; if (evt_if.evt_valid !== 1'b0) begin errors++; $display("FAIL latency_early got %0b want 0", evt_if.evt_valid); end
        @(negedge clk);
        checks++; if (evt_if.evt_valid !== 1'b1) begin errors++; $display("FAIL latency_valid got %0b want 1", evt_if.evt_valid); end
        checks++; if ({evt_if.evt_is_mouse, evt_if.evt_data} !== 17'h03A15) begin errors++; $display("FAIL single_payload got %0h want 3a15", {evt_if.evt_is_mouse, evt_if.evt_data}); end
        repeat (3) @(negedge clk);
        kb_data_avail = 1'b0;
        evt_if.evt_ready = 1'b1;
        n = 0;
        repeat (10) begin
            if (evt_if.evt_valid === 1'b1) n++;
            @(negedge clk);
        end
        evt_if.evt_ready = 1'b0;
        checks++; if (n !== 1) begin errors++; $display("FAIL held_level_events got %0d want 1", n); end
    endtask

    task automatic test_back_to_back();
        logic [16:0] exp;
        evt_if.evt_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_evt(1'b0, 16'hA000 + 16'(i));
        for (int i = 0; i < 3; i++) push_evt(1'b1, 16'hB000 + 16'(i));
        repeat (3) begin
            checks++; if ({evt_if.evt_valid, evt_if.evt_is_mouse, evt_if.evt_data} !== 18'h2A000) begin
                errors++; $display("FAIL stall_stable got %0h want 2a000", {evt_if.evt_valid, evt_if.evt_is_mouse, evt_if.evt_data}); end
            @(negedge clk);
        end
        evt_if.evt_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            exp = (k % 2 == 1) ? {1'b1, 16'hB000 + 16'(k / 2)} : {1'b0, 16'hA000 + 16'(k / 2)};
            checks++; if ({evt_if.evt_valid, evt_if.evt_is_mouse, evt_if.evt_data} !== {1'b1, exp}) begin
                errors++; $display("FAIL rr_order[%0d] got %0h want %0h", k, {evt_if.evt_valid, evt_if.evt_is_mouse, evt_if.evt_data}, {1'b1, exp}); end
            @(negedge clk);
        end
        checks++; if (evt_if.evt_valid !== 1'b0) begin errors++; $display("FAIL rr_drained got %0b want 0", evt_if.evt_valid); end
        evt_if.evt_ready = 1'b0;
    endtask

    task automatic test_overflow();
        evt_if.evt_ready = 1'b0;
        // A mouse event parks in the output slice first, so the keyboard
        // FIFO alone has to absorb the burst of ten.
        push_evt(1'b1, 16'hC0DE);
        for (int i = 0; i < 10; i++) push_evt(1'b0, 16'h0100 + 16'(i));
        checks++; if ({kb_ovf, ms_ovf} !== 2'b10) begin errors++; $display("FAIL ovf_set got %0b want 10", {kb_ovf, ms_ovf}); end
`ifdef KBD_SCHED_DROP_CNT_EN
        checks++; if (kb_drop_cnt !== 8'd2) begin errors++; $display("FAIL kb_drop_cnt got %0d want 2", kb_drop_cnt); end
`endif
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        checks++; if ({kb_ovf, ms_ovf} !== 2'b00) begin errors++; $display("FAIL ovf_clr got %0b want 00", {kb_ovf, ms_ovf}); end
`ifdef KBD_SCHED_DROP_CNT_EN
        checks++; if (kb_drop_cnt !== 8'd0) begin errors++; $display("FAIL kb_drop_cnt_clr got %0d want 0", kb_drop_cnt); end
`endif
        evt_if.evt_ready = 1'b1;
        checks++; if ({evt_if.evt_valid, evt_if.evt_is_mouse, evt_if.evt_data} !== 18'h3C0DE) begin
            errors++; $display("FAIL ovf_first got %0h want 3c0de", {evt_if.evt_valid, evt_if.evt_is_mouse, evt_if.evt_data}); end
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            checks++; if ({evt_if.evt_valid, evt_if.evt_is_mouse, evt_if.evt_data} !== {2'b10, 16'h0100 + 16'(i)}) begin
                errors++; $display("FAIL ovf_kb[%0d] got %0h want %0h", i, {evt_if.evt_valid, evt_if.evt_is_mouse, evt_if.evt_data}, {2'b10, 16'h0100 + 16'(i)}); end
            @(negedge clk);
        end
        checks++; if (evt_if.evt_valid !== 1'b0) begin errors++; $display("FAIL ovf_dropped_absent got %0b want 0", evt_if.evt_valid); end
        evt_if.evt_ready = 1'b0;
    endtask

    task automatic test_led_pair();
        led_window(2 * HOLD + 10, 0, 2'b01, -1, 2'b00, -1, 2'b00, 0, 2'b10);
        checks++; if (pulse_n !== 2) begin errors++; $display("FAIL led_pair_count got %0d want 2", pulse_n); end
        checks++; if (pulse_t[0] !== 2 || pulse_v[0] !== 2'b01) begin errors++; $display("FAIL led_pair_host got t=%0d v=%0b want t=2 v=01", pulse_t[0], pulse_v[0]); end
        checks++; if (pulse_t[1] !== 2 + HOLD || pulse_v[1] !== 2'b10) begin errors++; $display("FAIL led_pair_local got t=%0d v=%0b want t=%0d v=10", pulse_t[1], pulse_v[1], 2 + HOLD); end
        checks++; if (led_data_out !== 2'b10) begin errors++; $display("FAIL led_out_hold got %0b want 10", led_data_out); end
    endtask

    task automatic test_led_hold_requests();
        led_window(2 * HOLD + 10, 0, 2'b01, 10, 2'b11, 20, 2'b00, -1, 2'b00);
        checks++; if (pulse_n !== 2) begin errors++; $display("FAIL led_hold_count got %0d want 2", pulse_n); end
        checks++; if (pulse_t[1] !== 2 + HOLD || pulse_v[1] !== 2'b00) begin errors++; $display("FAIL led_hold_latest got t=%0d v=%0b want t=%0d v=00", pulse_t[1], pulse_v[1], 2 + HOLD); end
    endtask

    task automatic test_led_issue_collision();
        led_window(2 * HOLD + 10, 0, 2'b10, 2, 2'b01, -1, 2'b00, -1, 2'b00);
        checks++; if (pulse_n !== 2) begin errors++; $display("FAIL led_coll_count got %0d want 2", pulse_n); end
        checks++; if (pulse_t[0] !== 2 || pulse_v[0] !== 2'b10) begin errors++; $display("FAIL led_coll_first got t=%0d v=%0b want t=2 v=10", pulse_t[0], pulse_v[0]); end
        checks++; if (pulse_t[1] !== 2 + HOLD || pulse_v[1] !== 2'b01) begin errors++; $display("FAIL led_coll_kept got t=%0d v=%0b want t=%0d v=01", pulse_t[1], pulse_v[1], 2 + HOLD); end
    endtask

    task automatic test_reset_mid_hold();
        evt_if.evt_ready = 1'b0;
        push_evt(1'b0, 16'h5A5A); push_evt(1'b0, 16'h1234);
        push_evt(1'b1, 16'h4321); push_evt(1'b1, 16'h8765);
        led_window(5, 0, 2'b11, 1, 2'b01, -1, 2'b00, -1, 2'b00);
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({evt_if.evt_valid, evt_if.evt_data} !== 17'h0) begin errors++; $display("FAIL async_rst_evt got %0h want 0", {evt_if.evt_valid, evt_if.evt_data}); end
        checks++; if ({led_data_valid, led_data_out} !== 3'b000) begin errors++; $display("FAIL async_rst_led got %0b want 000", {led_data_valid, led_data_out}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (evt_if.evt_valid !== 1'b0) begin errors++; $display("FAIL rst_fifo_empty got %0b want 0", evt_if.evt_valid); end
        led_window(8, -1, 2'b00, -1, 2'b00, -1, 2'b00, 0, 2'b01);
        checks++; if (pulse_n !== 1 || pulse_t[0] !== 2 || pulse_v[0] !== 2'b01) begin
            errors++; $display("FAIL rst_led_restart got n=%0d t=%0d v=%0b want n=1 t=2 v=01", pulse_n, pulse_t[0], pulse_v[0]); end
    endtask

    task automatic test_random();
        logic [16:0] kbq[$];
        logic [16:0] msq[$];
        logic [16:0] m_stage;
        logic        m_av, m_valid, m_last, m_kovf, m_movf;
        logic        a, mm, r, clr, push, popk, popm, dk, dm;
        logic [15:0] d;
        int          m_kcnt, m_mcnt;
        do_reset();
        m_stage = '0; m_av = 1'b0; m_valid = 1'b0; m_last = 1'b1;
        m_kovf = 1'b0; m_movf = 1'b0; m_kcnt = 0; m_mcnt = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            checks++; if (evt_if.evt_valid !== m_valid) begin errors++; $display("FAIL rnd_valid@%0d got %0b want %0b", cyc, evt_if.evt_valid, m_valid); end
            if (m_valid) begin
                checks++; if ({evt_if.evt_is_mouse, evt_if.evt_data} !== m_stage) begin errors++; $display("FAIL rnd_payload@%0d got %0h want %0h", cyc, {evt_if.evt_is_mouse, evt_if.evt_data}, m_stage); end
            end
            checks++; if ({kb_ovf, ms_ovf} !== {m_kovf, m_movf}) begin errors++; $display("FAIL rnd_ovf@%0d got %0b want %0b", cyc, {kb_ovf, ms_ovf}, {m_kovf, m_movf}); end
`ifdef KBD_SCHED_DROP_CNT_EN
            checks++; if ({kb_drop_cnt, ms_drop_cnt} !== {8'(m_kcnt), 8'(m_mcnt)}) begin errors++; $display("FAIL rnd_drop_cnt@%0d got %0h want %0h", cyc, {kb_drop_cnt, ms_drop_cnt}, {8'(m_kcnt), 8'(m_mcnt)}); end
`endif
            a   = 1'($urandom_range(0, 1));
            mm  = 1'($urandom_range(0, 1));
            d   = 16'($urandom);
            r   = (cyc < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 31) == 0);
            kb_data_avail = a; kb_is_mouse = mm; kb_data = d;
            evt_if.evt_ready = r; ovf_clr = clr;
            // Reference: one-entry output slot fed round-robin from two queues.
            push = a & ~m_av;
            popk = 1'b0; popm = 1'b0;
            if (!m_valid || r) begin
                if (kbq.size() > 0 && (msq.size() == 0 || m_last)) begin
                    m_stage = kbq.pop_front(); popk = 1'b1; m_last = 1'b0;
                end else if (msq.size() > 0) begin
                    m_stage = msq.pop_front(); popm = 1'b1; m_last = 1'b1;
                end
                m_valid = popk | popm;
            end
            dk = 1'b0; dm = 1'b0;
            if (push && !mm) begin
                if (kbq.size() == KB_D && !popk) dk = 1'b1; else kbq.push_back({1'b0, d});
            end
            if (push && mm) begin
                if (msq.size() == MS_D && !popm) dm = 1'b1; else msq.push_back({1'b1, d});
            end
            m_kovf = dk ? 1'b1 : (clr ? 1'b0 : m_kovf);
            m_movf = dm ? 1'b1 : (clr ? 1'b0 : m_movf);
            m_kcnt = clr ? int'(dk) : ((dk && m_kcnt < 255) ? m_kcnt + 1 : m_kcnt);
            m_mcnt = clr ? int'(dm) : ((dm && m_mcnt < 255) ? m_mcnt + 1 : m_mcnt);
            m_av = a;
            @(negedge clk);
        end
        kb_data_avail = 1'b0; ovf_clr = 1'b0; evt_if.evt_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_back_to_back();
        test_overflow();
        test_led_pair();
        test_led_hold_requests();
        test_led_issue_collision();
        test_reset_mid_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
